// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4-way round-robin arbiter: FSM encodings and
// the default hold limit.
package mux4_rr_arbiter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam int MAX_HOLD_DEFAULT = 4;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Shared 4:1 single-bit data mux, built as an AND-OR of decoded selects.
module mux4_rr_arbiter_mux4 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    logic [3:0] hit;

    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
        assign hit[gi] = d[gi] && (sel == 2'(gi));
    end

    assign y = |hit;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters with a hold limit, steering a
// shared 4:1 data mux from the registered grant index.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Req,
    input  logic [3:0] Din,
    output logic [3:0] Grant,
    output logic [1:0] Sel,
    output logic       Valid,
    output logic       Out
);

    logic       state_q, state_d;
    logic [3:0] grant_q, grant_d;
    req_idx_t   sel_q, sel_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    req_idx_t   last_q, last_d;

    logic [3:0] cand;
    logic       pick_found;
    req_idx_t   pick_idx;
    logic       new_grant;
    logic       mux_y;

    // Returns {found, index} of the first set bit searched from last+1 with wrap.
    function automatic logic [2:0] rr_search(input logic [3:0] req, input req_idx_t last);
        logic     found;
        req_idx_t idx;
        req_idx_t res;
        found = 1'b0;
        res   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (req[idx] && !found) begin
                found = 1'b1;
                res   = idx;
            end
        end
        return {found, res};
    endfunction

    // Masking the current holder means a saturated holder can only be
    // replaced by someone else; in IDLE grant_q is zero so nothing is masked.
    assign cand = Req & ~grant_q;
    assign {pick_found, pick_idx} = rr_search(cand, last_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        new_grant  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) new_grant = 1'b1;
            end
            default: begin
                if (!Req[sel_q]) begin
                    if (pick_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_d    = 4'b0000;
                        hold_cnt_d = 4'd0;
                    end
                end else if (hold_cnt_q < 4'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else if (pick_found) begin
                    new_grant = 1'b1;
                end
            end
        endcase

        if (new_grant) begin
            state_d    = ST_BUSY;
            grant_d    = 4'b0001 << pick_idx;
            sel_d      = pick_idx;
            hold_cnt_d = 4'd1;
            last_d     = pick_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 4'b0000;
            sel_q      <= 2'd0;
            hold_cnt_q <= 4'd0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    mux4_rr_arbiter_mux4 u_mux (
        .d   (Din),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign Grant = grant_q;
    assign Sel   = sel_q;
    assign Valid = (state_q == ST_BUSY);
    assign Out   = mux_y && Valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, saturation, wrap,
// mux output gating and mid-grant reset.
module tb_mux4_rr_arbiter;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] Req;
    logic [3:0] Din;
    logic [3:0] Grant;
    logic [1:0] Sel;
    logic       Valid;
    logic       Out;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Req   (Req),
        .Din   (Din),
        .Grant (Grant),
        .Sel   (Sel),
        .Valid (Valid),
        .Out   (Out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic o);
        chk({tag, ".grant"}, 32'(Grant), 32'(g));
        chk({tag, ".sel"},   32'(Sel),   32'(s));
        chk({tag, ".valid"}, 32'(Valid), 32'(v));
        chk({tag, ".out"},   32'(Out),   32'(o));
        $display("%0t %s req=%b din=%b grant=%b sel=%0d valid=%b out=%b",
                 $time, tag, Req, Din, Grant, Sel, Valid, Out);
    endtask

    int          exp_idx;
    logic [3:0]  exp_grant;
    logic [3:0]  din_pat;

    initial begin
        Rst = 1'b1;
        Req = 4'b0000;
        Din = 4'b1111;
        step();
        step();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset.hold", 32'(dut.hold_cnt_q), 32'd0);

        // First grant goes to requester 0 after reset.
        Rst = 1'b0;
        Req = 4'b1111;
        Din = 4'b1010;
        step();
        chk_all("first", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Full rotation with all requesting: each holder keeps 4 cycles.
        din_pat = 4'b1010;
        for (int c = 1; c < 20; c++) begin
            step();
            exp_idx   = (c / 4) % 4;
            exp_grant = 4'b0001 << exp_idx;
            chk_all($sformatf("rot%0d", c), exp_grant, 2'(exp_idx), 1'b1, din_pat[exp_idx]);
        end

        // Lone requester 2 never rotates; hold counter saturates.
        Req = 4'b0100;
        Din = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step();
            chk_all($sformatf("solo%0d", c), 4'b0100, 2'd2, 1'b1, 1'b1);
        end
        chk("solo.hold", 32'(dut.hold_cnt_q), 32'd4);

        // Requester 3 takes over, then drops: wrap to 1, skipping 0.
        Req = 4'b1010;
        Din = 4'b0010;
        step();
        chk_all("r3a", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        chk_all("r3b", 4'b1000, 2'd3, 1'b1, 1'b0);
        Req = 4'b0010;
        step();
        chk_all("wrap", 4'b0010, 2'd1, 1'b1, 1'b1);

        // Back to idle: Sel holds, Out gated off.
        Req = 4'b0000;
        step();
        chk_all("idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        step();
        chk_all("idle2", 4'b0000, 2'd1, 1'b0, 1'b0);

        // From idle with Last=1, search starts at 2.
        Req = 4'b1111;
        Din = 4'b0100;
        step();
        chk_all("rearm", 4'b0100, 2'd2, 1'b1, 1'b1);
        step();
        chk_all("rearm2", 4'b0100, 2'd2, 1'b1, 1'b1);

        // Reset mid-grant drops it at once.
        Rst = 1'b1;
        step();
        chk_all("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        Rst = 1'b0;
        Din = 4'b0001;
        step();
        chk_all("postrst", 4'b0001, 2'd0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles before forced rotation when others request (legal range 1..15).
REQ-002 The block SHALL have port Clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port Req  input  4  request per requester; bit i is requester i.
REQ-005 The block SHALL have port Din  input  4  data bit per requester; bit i is requester i.
REQ-006 The block SHALL have port Grant  output  4  one-hot registered grant, or 4'b0000 when idle.
REQ-007 The block SHALL have port Sel  output  2  registered index of the granted requester, driving the shared 4:1 mux.
REQ-008 The block SHALL have port Valid  output  1  high while a grant is held.
REQ-009 The block SHALL have port Out  output  1  shared-mux output: Din[Sel] when Valid, else 0.

Function
REQ-010 The block SHALL use two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 The block SHALL sample Req on each rising Clk edge; Grant, Sel and Valid SHALL update at that edge, giving 1-cycle request-to-grant latency.
REQ-012 In IDLE with Req != 0, the block SHALL grant the first requesting index searched from (Last+1) mod 4 upward with wrap, then enter BUSY.
REQ-013 In IDLE with Req == 0, the block SHALL stay IDLE with Grant=0, Valid=0, and Sel holding its prior value.
REQ-014 In BUSY, the holder SHALL keep the grant while Req[Sel]=1 and HoldCnt < MAX_HOLD.
REQ-015 HoldCnt SHALL be a 4-bit counter, set to 1 on each new grant and incremented every BUSY cycle the holder keeps the grant, saturating at MAX_HOLD.
REQ-016 When HoldCnt == MAX_HOLD and any other Req bit is set, the block SHALL grant the next requester in round-robin order at the next edge, with no idle cycle.
REQ-017 When HoldCnt == MAX_HOLD and no other requester is active, the holder SHALL retain the grant and HoldCnt SHALL stay at MAX_HOLD.
REQ-018 When the holder deasserts Req[Sel], the block SHALL at that edge grant the next round-robin requester (back-to-back handover), or go to IDLE if Req == 0.
REQ-019 Last SHALL be a 2-bit register updated to the granted index on every new grant; round-robin search SHALL always start at (Last+1) mod 4 and wrap from 3 to 0.
REQ-020 Grant SHALL always be one-hot or zero, with Grant == (1 << Sel) whenever Valid=1.
REQ-021 Out SHALL be combinational from Din and the registered Sel, gated by Valid, with zero additional latency.

Reset
REQ-022 When Rst=1 at a rising edge, the block SHALL set state=IDLE, Grant=0, Sel=0, Valid=0, HoldCnt=0 and Last=3, so requester 0 has first priority after reset.
REQ-023 Rst SHALL take priority over all other inputs in the same cycle; asserting it mid-grant SHALL drop the grant at that edge with no handover.
REQ-024 While Rst is high, Out SHALL be 0 because Valid=0.

Structure
REQ-025 State encodings (IDLE=0, BUSY=1) and the default MAX_HOLD value SHALL live in a shared constants include file.
REQ-026 The shared data path SHALL be a single instance of the team's existing 4:1 mux sub-module, with Sel driving its select input and its output gated by Valid.
REQ-027 The round-robin next-index search SHALL be a combinational function inside this module, not a separate sub-module.

Verification
REQ-028 The bench SHALL apply Rst for 2 cycles, release it, then set Req=4'b1111 for 1 cycle; the next edge SHALL give Grant=0001, Sel=0, Valid=1.
REQ-029 The bench SHALL hold Req=4'b1111 with MAX_HOLD=4; grants SHALL be 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each held 4 cycles with no gap.
REQ-030 The bench SHALL set Req=4'b0100 alone for 10 cycles; Grant SHALL be 0100 throughout, HoldCnt SHALL saturate at 4, and no rotation SHALL occur.
REQ-031 The bench SHALL let requester 3 hold the grant with Req=1010, then drop Req[3]; the next edge SHALL give Grant=0010, showing wrap from 3 to 1 with index 0 skipped.
REQ-032 The bench SHALL apply Din=4'b0100 with Sel=2 and Valid=1; Out SHALL be 1. When Req then goes to 0 and the block returns to IDLE, Out SHALL be 0.
REQ-033 The bench SHALL assert Rst during BUSY with Req=1111; the next edge SHALL give Grant=0, and the first grant after release SHALL be 0001.
